// File: rtl/cpu_pkg.sv
// Shared MEM-stage definitions: funct3 access codes, FSM states, and
// load/store legality, alignment and lane-steering helpers.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: load_f3_ok = 1'b1;
      default:                        load_f3_ok = 1'b0;
    endcase
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: store_f3_ok = 1'b1;
      default:          store_f3_ok = 1'b0;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: addr_misaligned = lo[0];
      F3_W:        addr_misaligned = (lo != 2'b00);
      default:     addr_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B:    store_strb = 4'b0001 << lo;
      F3_H:    store_strb = 4'b0011 << {lo[1], 1'b0};
      F3_W:    store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  // Replicate the store value so every enabled lane carries the right bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_B:    store_lanes = {4{data[7:0]}};
      F3_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it according to funct3.
module load_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by width/sign extension.
  always_comb begin
    case (addr_lo_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (funct3_i)
      F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
      F3_H:    data_o = {{16{half_s[15]}}, half_s};
      F3_BU:   data_o = {24'h000000, byte_s};
      F3_HU:   data_o = {16'h0000, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives loads/stores onto a req/ack data bus, stalls EX
// while an access is outstanding, and registers the MEM/WB outputs.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_data,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regWrite,
  output logic        ex_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_memRead,
  output logic        wb_memWrite,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_alu_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regWrite,
  output logic        wb_misalign,
  output logic        wb_bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  mem_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        wb_valid_q, wb_memread_q, wb_memwrite_q, wb_regwrite_q;
  logic        wb_misalign_q, wb_bus_err_q;
  logic [31:0] wb_mem_data_q, wb_alu_q;
  logic [4:0]  wb_rd_q;

  logic        memop_s, fault_s, fault_op_s, start_s, timeout_s, done_s;
  logic [31:0] load_data_s;

  load_align u_load_align (
    .funct3_i  (ex_funct3),
    .addr_lo_i (ex_alu_data[1:0]),
    .rdata_i   (dmem_rdata),
    .data_o    (load_data_s)
  );

  // Classify the EX/MEM instruction and detect access completion.
  always_comb begin
    memop_s    = ex_valid & (ex_memRead | ex_memWrite);
    fault_s    = (ex_memRead  & ~load_f3_ok(ex_funct3))
               | (ex_memWrite & ~store_f3_ok(ex_funct3))
               | addr_misaligned(ex_funct3, ex_alu_data[1:0]);
    fault_op_s = memop_s & fault_s;
    start_s    = memop_s & ~fault_s;
    if (TIMEOUT_CYCLES == 0) begin
      timeout_s = 1'b0;
    end else begin
      timeout_s = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
    done_s     = (state_q == WAIT) & (dmem_ack | timeout_s);
  end

  assign ex_stall = start_s & ~done_s;

  // Access FSM with its bus registers and the MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      wstrb_q       <= 4'h0;
      wb_valid_q    <= 1'b0;
      wb_memread_q  <= 1'b0;
      wb_memwrite_q <= 1'b0;
      wb_mem_data_q <= 32'h0;
      wb_alu_q      <= 32'h0;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      wb_misalign_q <= 1'b0;
      wb_bus_err_q  <= 1'b0;
    end else begin
      // EX/MEM is held stable during a stall, so these can load every edge.
      wb_memread_q  <= ex_memRead;
      wb_memwrite_q <= ex_memWrite;
      wb_alu_q      <= ex_alu_data;
      wb_rd_q       <= ex_rd;
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_q    <= WAIT;
            cnt_q      <= '0;
            req_q      <= 1'b1;
            we_q       <= ex_memWrite;
            addr_q     <= {ex_alu_data[31:2], 2'b00};
            wdata_q    <= store_lanes(ex_funct3, ex_store_data);
            wstrb_q    <= ex_memWrite ? store_strb(ex_funct3, ex_alu_data[1:0]) : 4'b0000;
            wb_valid_q <= 1'b0;
          end else begin
            wb_valid_q    <= ex_valid;
            wb_mem_data_q <= 32'h0;
            wb_regwrite_q <= ex_regWrite & ~fault_op_s;
            wb_misalign_q <= fault_op_s;
            wb_bus_err_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            wb_valid_q    <= ex_valid;
            wb_mem_data_q <= ex_memWrite ? 32'h0 : load_data_s;
            wb_regwrite_q <= ex_regWrite;
            wb_misalign_q <= 1'b0;
            wb_bus_err_q  <= 1'b0;
          end else if (timeout_s) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            wb_valid_q    <= ex_valid;
            wb_mem_data_q <= 32'h0;
            wb_regwrite_q <= 1'b0;
            wb_misalign_q <= 1'b0;
            wb_bus_err_q  <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            wb_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          req_q      <= 1'b0;
          wb_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_wstrb  = wstrb_q;
  assign wb_valid    = wb_valid_q;
  assign wb_memRead  = wb_memread_q;
  assign wb_memWrite = wb_memwrite_q;
  assign wb_mem_data = wb_mem_data_q;
  assign wb_alu_data = wb_alu_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regWrite = wb_regwrite_q;
  assign wb_misalign = wb_misalign_q;
  assign wb_bus_err  = wb_bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table-driven single-cycle and memory
// vectors, a scoreboard of expected MEM/WB records, and a mid-access reset.
module tb_mem_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_memRead, ex_memWrite, ex_regWrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_data, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        wb_valid, wb_memRead, wb_memWrite, wb_regWrite, wb_misalign, wb_bus_err;
  logic [31:0] wb_mem_data, wb_alu_data;
  logic [4:0]  wb_rd;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_funct3(ex_funct3), .ex_alu_data(ex_alu_data), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_stall(ex_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_memRead(wb_memRead),
    .wb_memWrite(wb_memWrite), .wb_mem_data(wb_mem_data), .wb_alu_data(wb_alu_data),
    .wb_rd(wb_rd), .wb_regWrite(wb_regWrite), .wb_misalign(wb_misalign),
    .wb_bus_err(wb_bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid, rd_en, wr_en; logic [2:0] f3; logic [31:0] alu, sdata;
    logic [4:0] rd; logic rw; logic exp_mis, exp_rw;
  } sc_vec_t;

  typedef struct {
    logic [2:0] f3; logic wr; logic [31:0] alu, sdata, rdata; logic [4:0] rd;
    int delay; logic early_ack; logic [31:0] exp_data, exp_wdata; logic [3:0] exp_wstrb;
    logic exp_err;
  } mem_vec_t;

  typedef struct {
    logic rd_en, wr_en; logic [31:0] data, alu; logic [4:0] rd;
    logic rw, mis, err; int cyc;
  } wb_exp_t;

  wb_exp_t  sb[$];
  sc_vec_t  sc[11];
  mem_vec_t mv[10];
  mem_vec_t mrst;
  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw);
    ex_valid = v; ex_memRead = r; ex_memWrite = w; ex_funct3 = f3;
    ex_alu_data = alu; ex_store_data = sd; ex_rd = rd; ex_regWrite = rw;
  endtask

  // Scoreboard consumer: every wb_valid pulse must match the oldest expectation.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        if (sb.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL wb_unexpected: got wb_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("wb_cycle",    cyc,         e.cyc);
          check("wb_memRead",  wb_memRead,  e.rd_en);
          check("wb_memWrite", wb_memWrite, e.wr_en);
          check("wb_mem_data", wb_mem_data, e.data);
          check("wb_alu_data", wb_alu_data, e.alu);
          check("wb_rd",       wb_rd,       e.rd);
          check("wb_regWrite", wb_regWrite, e.rw);
          check("wb_misalign", wb_misalign, e.mis);
          check("wb_bus_err",  wb_bus_err,  e.err);
        end
      end
    end
  end

  task automatic mem_op(input mem_vec_t v);
    wb_exp_t e;
    int stalls, reqs, k, exp_n;
    bit done;
    @(negedge clk);
    drive(1'b1, ~v.wr, v.wr, v.f3, v.alu, v.sdata, v.rd, ~v.wr);
    dmem_ack = v.early_ack; dmem_rdata = 32'hDEAD_0000;
    exp_n = (v.delay >= 0) ? v.delay + 1 : TMO;
    e = '{~v.wr, v.wr, v.exp_data, v.alu, v.rd, ~v.wr & ~v.exp_err, 1'b0, v.exp_err, cyc + exp_n + 1};
    sb.push_back(e);
    #1;
    stalls = ex_stall ? 1 : 0;
    reqs = 0; k = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      if (dmem_req) reqs++;
      if (k == 0) begin
        check("bus_addr", dmem_addr, v.alu & 32'hFFFF_FFFC);
        check("bus_we",   dmem_we,   v.wr);
        if (v.wr) begin
          check("bus_wstrb", dmem_wstrb, v.exp_wstrb);
          check("bus_wdata", dmem_wdata, v.exp_wdata);
        end
      end
      if (k == v.delay) begin
        dmem_ack = 1'b1; dmem_rdata = v.rdata;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
      #1;
      if (ex_stall) stalls++;
      else done = 1'b1;
      k++;
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    dmem_ack = 1'b0;
    check("req_dropped", dmem_req, 32'd0);
    check("stall_cycles", stalls, exp_n);
    check("req_cycles", reqs, exp_n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            valid rd    wr    f3      alu            sdata          rd     rw    mis   exp_rw
    sc[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0,         5'd5,  1'b1, 1'b0, 1'b1};
    sc[1]  = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,         5'd7,  1'b1, 1'b1, 1'b0};
    sc[2]  = '{1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0,         5'd8,  1'b1, 1'b1, 1'b0};
    sc[3]  = '{1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0001, 32'h0,         5'd9,  1'b1, 1'b1, 1'b0};
    sc[4]  = '{1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h1111_2222, 5'd0,  1'b0, 1'b1, 1'b0};
    sc[5]  = '{1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,         5'd11, 1'b1, 1'b1, 1'b0};
    sc[6]  = '{1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0};
    sc[7]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,         5'd12, 1'b1, 1'b0, 1'b0};
    sc[8]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0,         5'd31, 1'b1, 1'b0, 1'b1};
    sc[9]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0004, 32'h0,         5'd1,  1'b0, 1'b0, 1'b0};
    sc[10] = '{1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0};

    //          f3      wr    alu            sdata          rdata          rd    dly early  exp_data       exp_wdata      wstrb    err
    mv[0] = '{3'b000, 1'b0, 32'h0000_0103, 32'h0,         32'h80FF_1234, 5'd3, 3,  1'b0, 32'hFFFF_FF80, 32'h0,         4'b0000, 1'b0};
    mv[1] = '{3'b001, 1'b1, 32'h0000_0102, 32'h0000_BEEF, 32'h0,         5'd0, 0,  1'b0, 32'h0,         32'hBEEF_BEEF, 4'b1100, 1'b0};
    mv[2] = '{3'b101, 1'b0, 32'h0000_0102, 32'h0,         32'h80FF_1234, 5'd4, 1,  1'b0, 32'h0000_80FF, 32'h0,         4'b0000, 1'b0};
    mv[3] = '{3'b001, 1'b0, 32'h0000_0102, 32'h0,         32'h80FF_1234, 5'd5, 2,  1'b0, 32'hFFFF_80FF, 32'h0,         4'b0000, 1'b0};
    mv[4] = '{3'b100, 1'b0, 32'h0000_0101, 32'h0,         32'h80FF_1234, 5'd6, 0,  1'b0, 32'h0000_0012, 32'h0,         4'b0000, 1'b0};
    mv[5] = '{3'b000, 1'b1, 32'h0000_0201, 32'h1234_56A5, 32'h0,         5'd0, 1,  1'b0, 32'h0,         32'hA5A5_A5A5, 4'b0010, 1'b0};
    mv[6] = '{3'b010, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,         5'd0, 2,  1'b0, 32'h0,         32'hCAFE_F00D, 4'b1111, 1'b0};
    mv[7] = '{3'b000, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_00F0, 5'd7, 0,  1'b0, 32'hFFFF_FFF0, 32'h0,         4'b0000, 1'b0};
    // Ack arrives in the same cycle the wait counter expires: data must win.
    mv[8] = '{3'b010, 1'b0, 32'h0000_0300, 32'h0,         32'h1122_3344, 5'd8, 3,  1'b0, 32'h1122_3344, 32'h0,         4'b0000, 1'b0};
    mv[9] = '{3'b010, 1'b0, 32'h0000_0304, 32'h0,         32'h0,         5'd9, -1, 1'b0, 32'h0,         32'h0,         4'b0000, 1'b1};
    mrst  = '{3'b010, 1'b0, 32'h0000_0208, 32'h0,         32'h5A5A_A5A5, 5'd10, 1, 1'b1, 32'h5A5A_A5A5, 32'h0,         4'b0000, 1'b0};

    rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_wb_valid", wb_valid, 32'd0);
    check("rst_dmem_req", dmem_req, 32'd0);
    check("rst_ex_stall", ex_stall, 32'd0);
    check("rst_bus", {dmem_we, dmem_wstrb, dmem_addr[26:0]}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wb_data", wb_mem_data | wb_alu_data, 32'd0);
    check("rst_wb_flags", {wb_memRead, wb_memWrite, wb_rd, wb_regWrite, wb_misalign, wb_bus_err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(sc[i].valid, sc[i].rd_en, sc[i].wr_en, sc[i].f3, sc[i].alu, sc[i].sdata, sc[i].rd, sc[i].rw);
      if (sc[i].valid)
        sb.push_back('{sc[i].rd_en, sc[i].wr_en, 32'h0, sc[i].alu, sc[i].rd,
                       sc[i].exp_rw, sc[i].exp_mis, 1'b0, cyc + 1});
      #1;
      check("sc_stall", ex_stall, 32'd0);
      check("sc_req", dmem_req, 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);

    for (int i = 0; i < 10; i++) mem_op(mv[i]);

    // Reset in the middle of an outstanding load, then a stray ack after release.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd9, 1'b1);
    repeat (2) @(negedge clk);
    check("midrst_req_before", dmem_req, 32'd1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    check("midrst_req_drop", dmem_req, 32'd0);
    check("midrst_addr", dmem_addr, 32'd0);
    check("midrst_wb_valid", wb_valid, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_op(mrst);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
